// File: rtl/approx_mul8_share_sched_pkg.sv
// Shared constants and row reduction helper for the approximate multiplier scheduler.
package approx_mul8_share_sched_pkg;

   localparam int unsigned HA_B_W     = 7;
   localparam int unsigned HA_T_W     = 9;
   localparam int unsigned ROW_SUM_W  = 10;
   localparam int unsigned PART_W     = 12;
   localparam int unsigned PROD_W     = 16;
   localparam int unsigned ROW_SHIFT  = 2;
   localparam int unsigned PAIR_SHIFT = 2 * ROW_SHIFT;

   // Row value from the array's sum and carry vectors; max 1019 fits in 10 bits.
   function automatic logic [ROW_SUM_W-1:0] row_value(input logic [HA_B_W-1:0] b,
                                                      input logic [HA_T_W-1:0] t);
      return ROW_SUM_W'(t) + (ROW_SUM_W'(b) << ROW_SHIFT);
   endfunction

endpackage

// File: rtl/approx_mul8_share_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered priority pointer.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            stall,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic            grant_valid
);

   logic [IDW-1:0] rr_q, rr_d;

   always_comb begin
      int unsigned    pos;
      logic [IDW-1:0] idx;
      grant       = '0;
      grant_id    = '0;
      grant_valid = 1'b0;
      pos         = 0;
      idx         = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         pos = 32'(rr_q) + i;
         if (pos >= NREQ) pos = pos - NREQ;
         idx = IDW'(pos);
         if (!grant_valid && !stall && req[idx]) begin
            grant_valid = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (grant_valid) begin
         rr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_q <= '0;
      else        rr_q <= rr_d;
   end

endmodule

// File: rtl/approx_mul8_share_sched.sv
// Shares one approximate 8x8 half-adder array among NREQ clients: arbitrate, register
// operands, reduce the four returned rows over two stages, and return the tagged product.
module approx_mul8_share_sched
   import approx_mul8_share_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_x,
   input  logic [NREQ*8-1:0] req_y,
   output logic [7:0]        mul_x,
   output logic [7:0]        mul_y,
   input  logic [6:0]        ha_0_b,
   input  logic [6:0]        ha_1_b,
   input  logic [6:0]        ha_2_b,
   input  logic [6:0]        ha_3_b,
   input  logic [8:0]        ha_0_t,
   input  logic [8:0]        ha_1_t,
   input  logic [8:0]        ha_2_t,
   input  logic [8:0]        ha_3_t,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [15:0]       res_data,
   output logic [IDW-1:0]    res_id,
   output logic              busy
);

   // Partials carry one bit beyond PART_W so out-of-range row vectors saturate, not wrap.
   localparam int unsigned PSUM_W = PART_W + 1;
   localparam int unsigned SUM_W  = PROD_W + 1;

   logic                 stall;
   logic [NREQ-1:0]      grant;
   logic [IDW-1:0]       grant_id;
   logic                 grant_valid;
   logic [7:0]           sel_x, sel_y;

   logic                 v0_q, v1_q, res_valid_q;
   logic [IDW-1:0]       id0_q, id1_q, res_id_q;
   logic [7:0]           mul_x_q, mul_y_q;
   logic [ROW_SUM_W-1:0] row0, row1, row2, row3;
   logic [PSUM_W-1:0]    p01_d, p23_d, p01_q, p23_q;
   logic [SUM_W-1:0]     sum;
   logic [PROD_W-1:0]    res_data_d, res_data_q;

   assign stall = res_valid_q & ~res_ready;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req_valid),
      .stall       (stall),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   assign req_ready = grant;

   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_x = req_x[8*i +: 8];
            sel_y = req_y[8*i +: 8];
         end
      end
   end

   // S0: operand register feeding the shared array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q    <= 1'b0;
         id0_q   <= '0;
         mul_x_q <= '0;
         mul_y_q <= '0;
      end else if (!stall) begin
         v0_q <= grant_valid;
         if (grant_valid) begin
            id0_q   <= grant_id;
            mul_x_q <= sel_x;
            mul_y_q <= sel_y;
         end
      end
   end

   assign row0  = row_value(ha_0_b, ha_0_t);
   assign row1  = row_value(ha_1_b, ha_1_t);
   assign row2  = row_value(ha_2_b, ha_2_t);
   assign row3  = row_value(ha_3_b, ha_3_t);
   assign p01_d = PSUM_W'(row0) + (PSUM_W'(row1) << ROW_SHIFT);
   assign p23_d = PSUM_W'(row2) + (PSUM_W'(row3) << ROW_SHIFT);

   // S1: row pair partial sums.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         id1_q <= '0;
         p01_q <= '0;
         p23_q <= '0;
      end else if (!stall) begin
         v1_q <= v0_q;
         if (v0_q) begin
            id1_q <= id0_q;
            p01_q <= p01_d;
            p23_q <= p23_d;
         end
      end
   end

   assign sum        = SUM_W'(p01_q) + (SUM_W'(p23_q) << PAIR_SHIFT);
   assign res_data_d = sum[PROD_W] ? '1 : sum[PROD_W-1:0];

   // S2: output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
      end else if (!stall) begin
         res_valid_q <= v1_q;
         if (v1_q) begin
            res_id_q   <= id1_q;
            res_data_q <= res_data_d;
         end
      end
   end

   assign mul_x     = mul_x_q;
   assign mul_y     = mul_y_q;
   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_data  = res_data_q;
   assign busy      = v0_q | v1_q | res_valid_q;

endmodule
